// File: rtl/multi_timer.sv
// Multi-channel programmable tick generator: each channel emits single-cycle
// ticks at a runtime period, periodic or one-shot, with optional delayed first tick.
module multi_timer #(
  parameter int NUM_CH                 = 4,
  parameter int CNT_W                  = 16,
  parameter int FIRST_TICK_AFTER_DELAY = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       restart,
  input  logic [NUM_CH-1:0]       oneshot,
  input  logic [NUM_CH*CNT_W-1:0] period,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic             TICK_AT_E0 = (FIRST_TICK_AFTER_DELAY == 0);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] per_q;
    logic             os_q;
    logic             tick_q;
    logic             busy_q;
    logic [CNT_W-1:0] per_cap_s;
    logic             start_s;

    // A zero period is treated as one so the channel ticks every cycle.
    assign per_cap_s = (period[i*CNT_W +: CNT_W] == '0) ? ONE : period[i*CNT_W +: CNT_W];
    assign start_s   = enable[i] && ((state_q == IDLE) || restart[i]);

    // Per-channel state machine with registered tick/busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        per_q   <= ONE;
        os_q    <= 1'b0;
        tick_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else if (!enable[i]) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        tick_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else if (start_s) begin
        per_q  <= per_cap_s;
        os_q   <= oneshot[i];
        cnt_q  <= '0;
        tick_q <= TICK_AT_E0;
        if (oneshot[i] && TICK_AT_E0) begin
          state_q <= HOLD;
          busy_q  <= 1'b0;
        end else begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (cnt_q == per_q - ONE) begin
              cnt_q  <= '0;
              tick_q <= 1'b1;
              if (os_q) begin
                state_q <= HOLD;
                busy_q  <= 1'b0;
              end else begin
                state_q <= RUN;
                busy_q  <= 1'b1;
              end
            end else begin
              cnt_q  <= cnt_q + ONE;
              tick_q <= 1'b0;
            end
          end
          HOLD: begin
            tick_q <= 1'b0;
            busy_q <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end

    assign tick[i] = tick_q;
    assign busy[i] = busy_q;
  end

endmodule

// File: tb/tb_multi_timer.sv
// Randomised and directed bench for multi_timer; two instances (immediate and
// delayed first tick) are compared every cycle against a time-since-start model.
module tb_multi_timer;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       en, rs, os;
  logic [NUM_CH*CNT_W-1:0] per;
  logic [NUM_CH-1:0]       tick0, busy0, tick1, busy1;

  always #5 clk = ~clk;

  multi_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .FIRST_TICK_AFTER_DELAY(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .enable(en), .restart(rs), .oneshot(os),
    .period(per), .tick(tick0), .busy(busy0));

  multi_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .FIRST_TICK_AFTER_DELAY(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .enable(en), .restart(rs), .oneshot(os),
    .period(per), .tick(tick1), .busy(busy1));

  int checks = 0;
  int errors = 0;

  // Model: per channel, whether it is started, edges since start, captured period/mode.
  bit                act_m [2][NUM_CH];
  int                n_m   [2][NUM_CH];
  int                p_m   [2][NUM_CH];
  bit                os_m  [2][NUM_CH];
  logic [NUM_CH-1:0] exp_t [2];
  logic [NUM_CH-1:0] exp_b [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        act_m[d][c] = 1'b0;
        n_m[d][c]   = 0;
      end
      exp_t[d] = '0;
      exp_b[d] = '0;
    end
  endfunction

  // Ticks fall on edges whose distance from the start edge is a multiple of P.
  function automatic void model_edge();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        int first;
        int pv;
        pv = int'(per[c*CNT_W +: CNT_W]);
        if (!en[c]) begin
          act_m[d][c] = 1'b0;
        end else if (!act_m[d][c] || rs[c]) begin
          act_m[d][c] = 1'b1;
          n_m[d][c]   = 0;
          p_m[d][c]   = (pv == 0) ? 1 : pv;
          os_m[d][c]  = os[c];
        end else begin
          n_m[d][c]++;
        end
        first = (d == 1) ? p_m[d][c] : 0;
        if (!act_m[d][c]) begin
          exp_t[d][c] = 1'b0;
          exp_b[d][c] = 1'b0;
        end else if (os_m[d][c]) begin
          exp_t[d][c] = (n_m[d][c] == first);
          exp_b[d][c] = (n_m[d][c] < first);
        end else begin
          exp_t[d][c] = (n_m[d][c] >= first) && ((n_m[d][c] % p_m[d][c]) == 0);
          exp_b[d][c] = 1'b1;
        end
      end
    end
  endfunction

  task automatic step(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("tick_d0", 32'(tick0), 32'(exp_t[0]));
      chk("busy_d0", 32'(busy0), 32'(exp_b[0]));
      chk("tick_d1", 32'(tick1), 32'(exp_t[1]));
      chk("busy_d1", 32'(busy1), 32'(exp_b[1]));
      rs = '0;
    end
  endtask

  task automatic set_ch(input int c, input bit e, input bit o, input int pv);
    en[c] = e;
    os[c] = o;
    per[c*CNT_W +: CNT_W] = CNT_W'(pv);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tick_d0"}, 32'(tick0), 32'd0);
    chk({tag, "_busy_d0"}, 32'(busy0), 32'd0);
    chk({tag, "_tick_d1"}, 32'(tick1), 32'd0);
    chk({tag, "_busy_d1"}, 32'(busy1), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    en = '0; rs = '0; os = '0; per = '0;
    model_reset();
    #2;
    check_zero("reset");
    #6 rst_n = 1'b1;

    // Periodic P=5 running, then asynchronous reset between edges.
    set_ch(0, 1'b1, 1'b0, 5);
    step(7);
    chk("busy_before_rst", 32'(busy0[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    en = '0;
    #2 rst_n = 1'b1;
    step(3);

    // Periodic P=4, then enable dropped.
    set_ch(0, 1'b1, 1'b0, 4);
    step(10);
    en[0] = 1'b0;
    step(4);

    // P=3 then P=1.
    set_ch(0, 1'b1, 1'b0, 3);
    step(8);
    en[0] = 1'b0;
    step(1);
    set_ch(0, 1'b1, 1'b0, 1);
    step(5);
    en[0] = 1'b0;
    step(1);

    // One-shot P=6, held, then re-armed by a restart pulse.
    set_ch(0, 1'b1, 1'b1, 6);
    step(27);
    rs[0] = 1'b1;
    step(10);
    en[0] = 1'b0;
    step(1);

    // Restart with a new period; later period changes without restart are ignored.
    set_ch(0, 1'b1, 1'b0, 5);
    step(3);
    per[0 +: CNT_W] = CNT_W'(3);
    rs[0] = 1'b1;
    step(10);
    per[0 +: CNT_W] = CNT_W'(7);
    step(10);
    en = '0;
    step(1);

    // Channel independence, all started on the same edge.
    set_ch(0, 1'b1, 1'b0, 2);
    set_ch(1, 1'b1, 1'b0, 7);
    set_ch(2, 1'b1, 1'b0, 0);
    set_ch(3, 1'b1, 1'b1, 1);
    step(50);
    en[1] = 1'b0;
    rs[1] = 1'b1;
    step(3);
    en = '0;
    step(1);

    // Maximum period.
    set_ch(2, 1'b1, 1'b0, (1 << CNT_W) - 1);
    step(520);
    en = '0;
    step(1);

    // Random stimulus; period/mode churn each cycle must only matter at starts.
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 19) == 0) en[c] = ~en[c];
        if ($urandom_range(0, 29) == 0) rs[c] = 1'b1;
        os[c] = 1'($urandom_range(0, 1));
        per[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 9));
      end
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
